// File: rtl/popcount_pkg.sv
// Shared definitions for the sequential popcount neuron: FSM encoding and datapath widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package popcount_pkg;

    // Width of one activation chunk fed to the shared popcount unit.
    localparam int CHUNK_W = 19;

    // Popcount result width; 0..31 covers both exact and approximate variants.
    localparam int PC_W = 5;

    // Evaluation FSM: accept, stream positive chunks, stream negative chunks, hold result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POS  = 2'd1,
        ST_NEG  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/popcount19_unit.sv
// Combinational 19-input popcount (exact variant bound here; approximate variants share this port list).
// Latency: 0 cycles, purely combinational.
// Backpressure: none, no state.
module popcount19_unit
    import popcount_pkg::*;
(
    input  logic [CHUNK_W-1:0] input_a,
    output logic [PC_W-1:0]    out
);

    // Exact count of set bits in the chunk; max 19 fits comfortably in PC_W bits.
    always_comb begin
        out = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            out = out + PC_W'(input_a[i]);
        end
    end

endmodule

// File: rtl/popcount_seq_neuron.sv
// Ternary neuron: time-shares one popcount19 unit over CHUNKS pos then CHUNKS neg chunks, sum >= thr.
// Latency: 2*CHUNKS+1 edges from accept (inclusive) to out_valid; next accept 2*CHUNKS+2 cycles apart at best.
// Backpressure: result held stable in DONE until out_ready; in_ready only in IDLE, busy requests are dropped.
module popcount_seq_neuron
    import popcount_pkg::*;
#(
    parameter int CHUNKS = 4,
    parameter int SUM_W  = $clog2(31*CHUNKS+1)+1
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHUNK_W*CHUNKS-1:0]   in_pos,
    input  logic [CHUNK_W*CHUNKS-1:0]   in_neg,
    input  logic signed [SUM_W-1:0]     in_thr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [SUM_W-1:0]     out_sum,
    output logic                        out_fire
);

    localparam int VEC_W = CHUNK_W * CHUNKS;
    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHUNKS - 1);

    state_e                   state;
    logic [IDX_W-1:0]         idx;
    logic signed [SUM_W-1:0]  acc;
    logic signed [SUM_W-1:0]  acc_next;
    logic signed [SUM_W-1:0]  thr_q;
    logic signed [SUM_W-1:0]  cnt_ext;
    logic [VEC_W-1:0]         pos_q;
    logic [VEC_W-1:0]         neg_q;
    logic [CHUNK_W-1:0]       pc_in;
    logic [PC_W-1:0]          pc_cnt;
    logic                     idx_last;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign idx_last  = (idx == IDX_LAST);

    // Select the captured chunk for the current phase; idle popcount input is held at zero.
    always_comb begin
        pc_in = '0;
        case (state)
            ST_POS:  pc_in = pos_q[int'(idx)*CHUNK_W +: CHUNK_W];
            ST_NEG:  pc_in = neg_q[int'(idx)*CHUNK_W +: CHUNK_W];
            default: pc_in = '0;
        endcase
    end

    popcount19_unit u_popcount (
        .input_a (pc_in),
        .out     (pc_cnt)
    );

    // Count is always non-negative, so widen with zeros before the signed add/subtract.
    assign cnt_ext = SUM_W'(pc_cnt);

    // Same-cycle accumulate: add in POS, subtract in NEG.
    always_comb begin
        acc_next = acc;
        case (state)
            ST_POS:  acc_next = acc + cnt_ext;
            ST_NEG:  acc_next = acc - cnt_ext;
            default: acc_next = acc;
        endcase
    end

    // Evaluation FSM, operand capture and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            acc      <= '0;
            pos_q    <= '0;
            neg_q    <= '0;
            thr_q    <= '0;
            out_sum  <= '0;
            out_fire <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        pos_q <= in_pos;
                        neg_q <= in_neg;
                        thr_q <= in_thr;
                        acc   <= '0;
                        idx   <= '0;
                        state <= ST_POS;
                    end
                end
                ST_POS: begin
                    acc <= acc_next;
                    if (idx_last) begin
                        idx   <= '0;
                        state <= ST_NEG;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_NEG: begin
                    acc <= acc_next;
                    if (idx_last) begin
                        idx      <= '0;
                        out_sum  <= acc_next;
                        out_fire <= (acc_next >= thr_q);
                        state    <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_seq_neuron.sv
// Self-checking bench for popcount_seq_neuron: directed table, hold/reset sequences, random scoreboard.
// Latency: expects 2*CHUNKS+1 edges accept-to-valid and >= 2*CHUNKS+2 cycles between accepts.
// Backpressure: drives random out_ready and checks the held result.
module tb_popcount_seq_neuron;

    localparam int CHUNKS = 4;
    localparam int VW     = 19 * CHUNKS;
    localparam int SW     = $clog2(31*CHUNKS+1)+1;
    localparam int LAT    = 2*CHUNKS + 1;
    localparam int PERIOD = 2*CHUNKS + 2;
    localparam int N_RND  = 1000;

    typedef logic [VW-1:0]        vec_t;
    typedef logic signed [SW-1:0] sum_t;
    typedef struct { string nm; vec_t pos; vec_t neg; sum_t thr; int e_sum; bit e_fire; } vrec_t;
    typedef struct { int s; bit f; } exp_t;

    logic clk;
    logic rst;
    logic in_valid;
    logic in_ready;
    vec_t in_pos;
    vec_t in_neg;
    sum_t in_thr;
    logic out_valid;
    logic out_ready;
    sum_t out_sum;
    logic out_fire;

    int n_cmp = 0;
    int n_bad = 0;

    int   cyc = 0;
    int   last_acc = 0;
    int   n_acc = 0;
    bit   rnd_on = 1'b0;
    exp_t exp_q[$];
    vrec_t tbl[7];

    popcount_seq_neuron #(.CHUNKS(CHUNKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pos    (in_pos),
        .in_neg    (in_neg),
        .in_thr    (in_thr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_fire  (out_fire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input bit ok, input longint act, input longint exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: signed sum is just total ones in pos minus total ones in neg.
    function automatic exp_t model(input vec_t p, input vec_t n, input sum_t t);
        exp_t e;
        e.s = $countones(p) - $countones(n);
        e.f = (e.s >= int'(t));
        return e;
    endfunction

    function automatic vec_t rand_vec();
        logic [95:0] a;
        logic [95:0] b;
        a = {$urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom};
        case ($urandom_range(0, 4))
            0:       return a[VW-1:0] & b[VW-1:0];
            1:       return a[VW-1:0] | b[VW-1:0];
            2:       return '0;
            3:       return '1;
            default: return a[VW-1:0];
        endcase
    endfunction

    function automatic sum_t rand_thr();
        int t;
        t = int'($urandom_range(0, 160)) - 80;
        return sum_t'(t);
    endfunction

    // Starts at posedge+2; returns at the negedge where out_valid is first seen.
    task automatic send(input vec_t p, input vec_t n, input sum_t t,
                        output int s, output bit f, output int lat);
        bit got;
        got = 1'b0;
        in_pos = p; in_neg = n; in_thr = t; in_valid = 1'b1;
        for (int g = 0; g < 30 && !got; g++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        in_pos = ~p; in_neg = ~n; in_thr = ~t;
        s = 0; f = 1'b0; lat = 0;
        if (!got) begin
            check("accept_timeout", 1'b0, 0, 1);
            return;
        end
        lat = 1;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        s = int'(out_sum);
        f = out_fire;
    endtask

    // Called at a negedge in DONE; returns at posedge+2 with the transfer done.
    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_after_xfer", in_ready && !out_valid, {in_ready, out_valid}, 2);
        #1 out_ready = 1'b0;
    endtask

    // Random-phase scoreboard: record accepts, check spacing, compare completed results.
    always @(negedge clk) begin
        if (rnd_on && !rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_pos, in_neg, in_thr));
                if (n_acc > 0) check("req_period", (cyc - last_acc) >= PERIOD, cyc - last_acc, PERIOD);
                last_acc = cyc;
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", 1'b0, 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rnd_sum", int'(out_sum) == e.s, int'(out_sum), e.s);
                    check("rnd_fire", out_fire == e.f, out_fire, e.f);
                end
            end
        end
    end

    initial begin
        vec_t ones;
        vec_t zero;
        vec_t c2p;
        vec_t c0n;
        vec_t top;
        int   s;
        bit   f;
        int   lat;
        exp_t e;
        vec_t p;
        vec_t n;
        sum_t t;

        ones = '1;
        zero = '0;
        c2p  = '0; c2p[38 +: 5] = 5'h1f;
        c0n  = '0; c0n[0 +: 3]  = 3'h7;
        top  = '0; top[VW-1]    = 1'b1;

        tbl[0] = '{"all_pos",      ones, zero, sum_t'(50),  76,  1'b1};
        tbl[1] = '{"all_neg_eq",   zero, ones, sum_t'(-76), -76, 1'b1};
        tbl[2] = '{"all_neg_gt",   zero, ones, sum_t'(-75), -76, 1'b0};
        tbl[3] = '{"chunk_order",  c2p,  c0n,  sum_t'(2),   2,   1'b1};
        tbl[4] = '{"chunk_thr_hi", c2p,  c0n,  sum_t'(3),   2,   1'b0};
        tbl[5] = '{"cancel",       ones, ones, sum_t'(0),   0,   1'b1};
        tbl[6] = '{"top_bit",      top,  zero, sum_t'(1),   1,   1'b1};

        rst = 1'b1; in_valid = 1'b0; in_pos = '0; in_neg = '0; in_thr = '0; out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        check("rst_out_sum",   out_sum == '0, int'(out_sum), 0);
        check("rst_out_fire",  out_fire == 1'b0, out_fire, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready == 1'b1, in_ready, 1);
        @(posedge clk); #2;

        // Directed table
        for (int i = 0; i < $size(tbl); i++) begin
            send(tbl[i].pos, tbl[i].neg, tbl[i].thr, s, f, lat);
            check({tbl[i].nm, "_sum"},  s == tbl[i].e_sum, s, tbl[i].e_sum);
            check({tbl[i].nm, "_fire"}, f == tbl[i].e_fire, f, tbl[i].e_fire);
            check({tbl[i].nm, "_lat"},  lat == LAT, lat, LAT);
            release_out();
        end

        // Back-pressure: DONE held for 20 cycles while inputs churn
        p = rand_vec(); n = rand_vec(); t = rand_thr();
        e = model(p, n, t);
        send(p, n, t, s, f, lat);
        check("bp_sum", s == e.s, s, e.s);
        check("bp_fire", f == e.f, f, e.f);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #2;
            in_valid = 1'($urandom_range(0, 1));
            in_pos = rand_vec(); in_neg = rand_vec(); in_thr = rand_thr();
            @(negedge clk);
            check("bp_hold", out_valid && !in_ready && int'(out_sum) == e.s && out_fire == e.f,
                  int'(out_sum), e.s);
        end
        in_valid = 1'b0;
        release_out();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_not_queued", !out_valid && in_ready, {out_valid, in_ready}, 1);
        end

        // Reset in cycle 5 of an evaluation
        @(posedge clk); #2;
        in_pos = ones; in_neg = zero; in_thr = '0; in_valid = 1'b1;
        @(negedge clk);
        check("rst_mid_accept", in_ready == 1'b1, in_ready, 1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_async_ready", in_ready == 1'b1 && out_valid == 1'b0, {in_ready, out_valid}, 2);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_release", in_ready && !out_valid && out_sum == '0 && !out_fire,
              {in_ready, out_valid}, 2);
        @(posedge clk); #2;
        send(zero, c0n, sum_t'(-3), s, f, lat);
        check("post_rst_sum",  s == -3, s, -3);
        check("post_rst_fire", f == 1'b1, f, 1);
        check("post_rst_lat",  lat == LAT, lat, LAT);

        // Reset while holding a result drops out_valid at once
        rst = 1'b1;
        #1;
        check("rst_done_async", out_valid == 1'b0, out_valid, 0);
        @(posedge clk); #2 rst = 1'b0;

        // Random traffic with random back-pressure
        rnd_on = 1'b1;
        for (int c = 0; c < 60000 && n_acc < N_RND; c++) begin
            @(posedge clk); #2;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pos    = rand_vec();
            in_neg    = rand_vec();
            in_thr    = rand_thr();
            out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        check("rnd_drained", exp_q.size() == 0, exp_q.size(), 0);
        check("rnd_count", n_acc >= N_RND, n_acc, N_RND);
        rnd_on = 1'b0;
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/popcount_seq_neuron.md
# popcount_seq_neuron

Sequential ternary-neuron evaluator that time-shares one 19-input popcount unit across a wide input vector. It accepts positive-weight and negative-weight masked activation vectors of CHUNKS×19 bits, streams one 19-bit chunk per cycle through the shared popcount, and accumulates a signed sum (positive count minus negative count). It then compares the sum against a threshold and returns the neuron output over a valid/ready handshake. It sits between the activation buffer and the neuron output register file in the printed-NN datapath.

## Interface
- CHUNKS, default 4: number of 19-bit chunks per vector; legal range 1..16.
- SUM_W, default $clog2(31*CHUNKS+1)+1 (= 8 for CHUNKS=4): signed accumulator and threshold width.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  high only in IDLE.
- in_pos  input  19*CHUNKS  positive-weight masked activations; chunk k = bits [19k+18:19k].
- in_neg  input  19*CHUNKS  negative-weight masked activations; same layout.
- in_thr  input  SUM_W  signed threshold.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer ready.
- out_sum  output  SUM_W  signed accumulated sum (pos − neg).
- out_fire  output  1  1 when out_sum >= in_thr (signed compare).

## Operation
- FSM states: IDLE, POS, NEG, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_pos, in_neg and in_thr into internal registers, clear the accumulator, set chunk index idx=0, go to POS.
- POS: the popcount unit input is the captured pos chunk idx; acc += zero-extended 5-bit count.
  - If idx==CHUNKS−1: idx=0, go to NEG. Otherwise idx++.
- NEG: the popcount unit input is the captured neg chunk idx; acc −= count.
  - If idx==CHUNKS−1: register out_sum=acc_next and out_fire=(acc_next >= thr), go to DONE. Otherwise idx++.
- DONE:
  - out_valid=1; out_sum and out_fire are held stable.
  - On out_ready: go to IDLE.
- The popcount unit is combinational. Its 5-bit output is added within the same cycle; there is no pipeline stage inside the unit.
- Width rule: every count is treated as 0..31, so the 5-bit output of an approximate variant can never overflow. SUM_W covers the range ±31·CHUNKS, so no saturation is needed.
- Input vectors are only sampled at the accept edge. Changes to in_pos, in_neg or in_thr after that edge have no effect on the running evaluation.
- When no evaluation is running, the popcount unit input is driven to 0.

## Timing
- Reset values:
  - State=IDLE, idx=0, acc=0.
  - out_valid=0, out_sum=0, out_fire=0.
  - in_ready=1 once reset is deasserted.
- Cycle 0: accept edge (in_valid && in_ready).
- Cycles 1..CHUNKS: POS. Cycles CHUNKS+1..2·CHUNKS: NEG.
- out_valid rises after the edge that ends cycle 2·CHUNKS. Latency from the accept edge to out_valid is 2·CHUNKS+1 edges (9 for CHUNKS=4).
- Handshake: out_valid && out_ready completes the transfer at that edge.
  - in_ready returns the following cycle, so the minimum period between requests is 2·CHUNKS+2 cycles.
  - in_ready is never high while out_valid is high.
- Back-pressure: DONE holds indefinitely, and out_sum/out_fire must not change while out_valid=1.
- in_valid held while busy: ignored, not queued.
- Reset asserted mid-operation: all state clears asynchronously and out_valid drops immediately. There is no partial result.
- CHUNKS=1: POS and NEG each last exactly one cycle.

## Structure
- The shared package popcount_pkg holds:
  - the state enum (IDLE/POS/NEG/DONE),
  - the constant CHUNK_W=19,
  - the constant PC_W=5.
- One sub-module: popcount19_unit, with input_a[18:0] and out[4:0]. It wraps the chosen exact or approximate popcount19 variant.
  - The bench binds the exact variant.
  - Production binds an approximate variant.
  - The controller does not depend on which variant is bound.

## Test plan
- Reset, then in_pos all ones, in_neg=0, thr=50 (CHUNKS=4) -> out_valid at edge 9, out_sum=76, out_fire=1.
- in_pos=0, in_neg all ones, thr=−76 -> out_sum=−76, out_fire=1. The same vectors with thr=−75 -> out_fire=0.
- Chunk 2 of pos has 5 ones, chunk 0 of neg has 3 ones, everything else 0, thr=2 -> out_sum=2, out_fire=1. This checks chunk ordering and boundary equality.
- Hold out_ready=0 for 20 cycles in DONE while toggling in_valid and inputs -> out_valid, out_sum and out_fire stay stable, in_ready stays 0, and no new request is accepted.
- Assert rst during cycle 5 of an evaluation -> out_valid=0 and in_ready=1 immediately after release. The next request's result matches the model with no leftover accumulation.
- Random vectors, 1000 requests, random out_ready back-pressure -> every result equals the exact reference model, and the request period is never below 10 cycles.
